// File: rtl/ccg_bist_pkg.sv
// Shared types and constants for the ccg_bist controller: FSM state encodings,
// default CUT widths and the LFSR/MISR feedback tap masks.
package ccg_bist_pkg;

    localparam int IN_W_DEF  = 10;
    localparam int OUT_W_DEF = 15;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_CMP   = 2'd3;

    // Tap masks: feedback bit is the XOR of the masked register bits.
    // LFSR x^10+x^7+1 -> bits 9 and 6; MISR x^15+x^14+1 -> bits 14 and 13.
    localparam logic [IN_W_DEF-1:0]  LFSR_TAPS = 10'h240;
    localparam logic [OUT_W_DEF-1:0] MISR_TAPS = 15'h6000;

endpackage

// File: rtl/ccg_bist_if.sv
// Run-control and CUT-facing signal bundle between a BIST requester (master)
// and the ccg_bist_ctrl controller (slave).
interface ccg_bist_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 15,
    parameter int CNT_W = 11
);
    logic             start;
    logic [IN_W-1:0]  seed_in;
    logic [OUT_W-1:0] golden_sig;
    logic [IN_W-1:0]  cut_x;
    logic [OUT_W-1:0] cut_f;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;
    logic [CNT_W-1:0] pattern_cnt;

    modport master (
        output start, seed_in, golden_sig, cut_f,
        input  cut_x, busy, done, pass, signature, pattern_cnt
    );

    modport slave (
        input  start, seed_in, golden_sig, cut_f,
        output cut_x, busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/ccg_misr.sv
// Multiple-input signature register with configurable width and feedback taps;
// sig_next exposes the value the register would take on an enabled fold.
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int               WIDTH = OUT_W_DEF,
    parameter logic [WIDTH-1:0] TAPS  = MISR_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    logic [WIDTH-1:0] sig_r;

    assign sig_next = {sig_r[WIDTH-2:0], ^(sig_r & TAPS)} ^ din;
    assign sig      = sig_r;

    // Signature register: clear wins over fold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            sig_r <= {WIDTH{1'b0}};
        end else if (en) begin
            sig_r <= sig_next;
        end else begin
            sig_r <= sig_r;
        end
    end

endmodule

// File: rtl/ccg_bist_ctrl.sv
// LFSR-driven BIST controller with MISR compaction and golden compare.
// Optional macro CCG_BIST_PIPE_EN registers cut_f ahead of the MISR and adds a DRAIN state.
module ccg_bist_ctrl
    import ccg_bist_pkg::*;
#(
    parameter int                IN_W       = IN_W_DEF,
    parameter int                OUT_W      = OUT_W_DEF,
    parameter int                N_PATTERNS = 1024,
    parameter logic [IN_W-1:0]   L_TAPS     = LFSR_TAPS,
    parameter logic [OUT_W-1:0]  M_TAPS     = MISR_TAPS,
    localparam int               CNT_W      = $clog2(N_PATTERNS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    ccg_bist_if.slave  bus
);

    state_t           state_r;
    logic [IN_W-1:0]  cut_x_r;
    logic [CNT_W-1:0] cnt_r;
    logic [OUT_W-1:0] golden_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [IN_W-1:0]  lfsr_next_s;
    logic             accept_s;
    logic             last_s;
    logic             misr_en_s;
    logic [OUT_W-1:0] misr_din_s;
    logic [OUT_W-1:0] sig_s;
    logic [OUT_W-1:0] sig_next_s;

    assign lfsr_next_s = {cut_x_r[IN_W-2:0], ^(cut_x_r & L_TAPS)};
    assign accept_s    = (state_r == ST_IDLE) && bus.start;
    assign last_s      = (cnt_r == CNT_W'(N_PATTERNS - 1));

`ifdef CCG_BIST_PIPE_EN
    logic [OUT_W-1:0] cut_f_r;

    // Response pipeline stage; the first RUN cycle has nothing to fold yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            cut_f_r <= {OUT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            cut_f_r <= bus.cut_f;
        end else begin
            cut_f_r <= cut_f_r;
        end
    end

    assign misr_en_s  = ((state_r == ST_RUN) && (cnt_r != {CNT_W{1'b0}})) || (state_r == ST_DRAIN);
    assign misr_din_s = cut_f_r;
`else
    assign misr_en_s  = (state_r == ST_RUN);
    assign misr_din_s = bus.cut_f;
`endif

    ccg_misr #(
        .WIDTH (OUT_W),
        .TAPS  (M_TAPS)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept_s),
        .en       (misr_en_s),
        .din      (misr_din_s),
        .sig      (sig_s),
        .sig_next (sig_next_s)
    );

    // Run sequencing: done/pass are registered on the edge that enters CMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cut_x_r  <= {IN_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            golden_r <= {OUT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r  <= ST_RUN;
                        cut_x_r  <= (bus.seed_in == {IN_W{1'b0}}) ? IN_W'(1) : bus.seed_in;
                        cnt_r    <= {CNT_W{1'b0}};
                        golden_r <= bus.golden_sig;
                        busy_r   <= 1'b1;
                        pass_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cut_x_r <= lfsr_next_s;
                    if (cnt_r != CNT_W'(N_PATTERNS)) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    if (last_s) begin
`ifdef CCG_BIST_PIPE_EN
                        state_r <= ST_DRAIN;
`else
                        state_r <= ST_CMP;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        pass_r  <= (sig_next_s == golden_r);
`endif
                    end
                end
`ifdef CCG_BIST_PIPE_EN
                ST_DRAIN: begin
                    state_r <= ST_CMP;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    pass_r  <= (sig_next_s == golden_r);
                end
`endif
                ST_CMP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cut_x       = cut_x_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.pass        = pass_r;
    assign bus.signature   = sig_s;
    assign bus.pattern_cnt = cnt_r;

endmodule

// File: tb/tb_ccg_bist_ctrl.sv
// Directed bench for ccg_bist_ctrl: a 2-pattern instance for hand-computed runs
// and a 1024-pattern instance for reset mid-run and the full LFSR period.
module tb_ccg_bist_ctrl;

`ifdef CCG_BIST_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ccg_bist_if #(.IN_W(10), .OUT_W(15), .CNT_W(2))  bus_a ();
    ccg_bist_if #(.IN_W(10), .OUT_W(15), .CNT_W(11)) bus_b ();

    ccg_bist_ctrl #(.IN_W(10), .OUT_W(15), .N_PATTERNS(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ccg_bist_ctrl #(.IN_W(10), .OUT_W(15), .N_PATTERNS(1024)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus_a.cut_x !== 10'h000) begin errors++; $display("FAIL reset_cut_x got %h want 000", bus_a.cut_x); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus_a.done); end
        checks++; if (bus_a.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", bus_a.pass); end
        checks++; if (bus_a.signature !== 15'h0000) begin errors++; $display("FAIL reset_sig got %h want 0000", bus_a.signature); end
        checks++; if (bus_a.pattern_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus_a.pattern_cnt); end
    endtask

    task automatic test_two_pattern();
        bus_a.seed_in = 10'h001; bus_a.cut_f = 15'h0001; bus_a.golden_sig = 15'h0003;
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        checks++; if (bus_a.cut_x !== 10'h001) begin errors++; $display("FAIL two_cut_x0 got %h want 001", bus_a.cut_x); end
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL two_busy got %b want 1", bus_a.busy); end
        cyc();
        checks++; if (bus_a.cut_x !== 10'h002) begin errors++; $display("FAIL two_cut_x1 got %h want 002", bus_a.cut_x); end
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL two_done_early got %b want 0", bus_a.done); end
        cyc();
`ifdef CCG_BIST_PIPE_EN
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL two_done_drain got %b want 0", bus_a.done); end
        cyc();
`endif
        checks++; if (bus_a.done !== 1'b1) begin errors++; $display("FAIL two_done got %b want 1", bus_a.done); end
        checks++; if (bus_a.pass !== 1'b1) begin errors++; $display("FAIL two_pass got %b want 1", bus_a.pass); end
        checks++; if (bus_a.signature !== 15'h0003) begin errors++; $display("FAIL two_sig got %h want 0003", bus_a.signature); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL two_busy_fall got %b want 0", bus_a.busy); end
        checks++; if (bus_a.pattern_cnt !== 2'd2) begin errors++; $display("FAIL two_cnt got %0d want 2", bus_a.pattern_cnt); end
        cyc();
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL two_done_pulse got %b want 0", bus_a.done); end
        checks++; if (bus_a.pass !== 1'b1) begin errors++; $display("FAIL two_pass_hold got %b want 1", bus_a.pass); end
        checks++; if (bus_a.signature !== 15'h0003) begin errors++; $display("FAIL two_sig_hold got %h want 0003", bus_a.signature); end
    endtask

    task automatic test_zero_response();
        logic [14:0] goldens [2];
        logic        want_pass [2];
        goldens[0] = 15'h0000; want_pass[0] = 1'b1;
        goldens[1] = 15'h0001; want_pass[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_a.seed_in = 10'h155; bus_a.cut_f = 15'h0000; bus_a.golden_sig = goldens[i];
            bus_a.start = 1'b1;
            cyc();
            bus_a.start = 1'b0;
            for (int k = 0; k < 2 + PIPE; k++) cyc();
            checks++; if (bus_a.done !== 1'b1) begin errors++; $display("FAIL zero_done[%0d] got %b want 1", i, bus_a.done); end
            checks++; if (bus_a.pass !== want_pass[i]) begin errors++; $display("FAIL zero_pass[%0d] got %b want %b", i, bus_a.pass, want_pass[i]); end
            checks++; if (bus_a.signature !== 15'h0000) begin errors++; $display("FAIL zero_sig[%0d] got %h want 0000", i, bus_a.signature); end
            cyc();
        end
    endtask

    task automatic test_back_to_back_start();
        int   done_cnt;
        int   done_at;
        logic busy_after;
        done_cnt = 0; done_at = -1; busy_after = 1'b1;
        bus_a.seed_in = 10'h001; bus_a.cut_f = 15'h0001; bus_a.golden_sig = 15'h0003;
        bus_a.start = 1'b1;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            if (bus_a.done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 4 + PIPE) busy_after = bus_a.busy;
            bus_a.start = (k <= 3 + PIPE) ? 1'b1 : 1'b0;
            cyc();
        end
        bus_a.start = 1'b0;
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt); end
        checks++; if (done_at !== 3 + PIPE) begin errors++; $display("FAIL b2b_done_time got T+%0d want T+%0d", done_at, 3 + PIPE); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL b2b_no_requeue busy got %b want 0", busy_after); end
        checks++; if (bus_a.signature !== 15'h0003) begin errors++; $display("FAIL b2b_sig got %h want 0003", bus_a.signature); end
    endtask

    task automatic test_reset_midrun();
        bus_b.seed_in = 10'h3AB; bus_b.cut_f = 15'h1234; bus_b.golden_sig = 15'h0000;
        bus_b.start = 1'b1;
        cyc();
        bus_b.start = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        checks++; if (bus_b.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus_b.busy); end
        checks++; if (bus_b.signature === 15'h0000) begin errors++; $display("FAIL mid_sig got %h want nonzero", bus_b.signature); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (bus_b.cut_x !== 10'h000) begin errors++; $display("FAIL mid_rst_cut_x got %h want 000", bus_b.cut_x); end
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", bus_b.busy); end
        checks++; if (bus_b.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", bus_b.done); end
        checks++; if (bus_b.pass !== 1'b0) begin errors++; $display("FAIL mid_rst_pass got %b want 0", bus_b.pass); end
        checks++; if (bus_b.signature !== 15'h0000) begin errors++; $display("FAIL mid_rst_sig got %h want 0000", bus_b.signature); end
        checks++; if (bus_b.pattern_cnt !== 11'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", bus_b.pattern_cnt); end
        cyc();
        cyc();
        checks++; if (bus_b.done !== 1'b0 || bus_b.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle done=%b busy=%b want 0 0", bus_b.done, bus_b.busy); end
    endtask

    task automatic test_zero_seed_full_run();
        int done_at;
        done_at = -1;
        bus_b.seed_in = 10'h000; bus_b.cut_f = 15'h0000; bus_b.golden_sig = 15'h0000;
        bus_b.start = 1'b1;
        cyc();
        bus_b.start = 1'b0;
        checks++; if (bus_b.cut_x !== 10'h001) begin errors++; $display("FAIL seed0_cut_x got %h want 001", bus_b.cut_x); end
        checks++; if (bus_b.busy !== 1'b1) begin errors++; $display("FAIL seed0_busy got %b want 1", bus_b.busy); end
        cyc();
        checks++; if (bus_b.cut_x !== 10'h002) begin errors++; $display("FAIL seed0_step1 got %h want 002", bus_b.cut_x); end
        for (int k = 3; k <= 1024; k++) cyc();
        checks++; if (bus_b.cut_x !== 10'h001) begin errors++; $display("FAIL lfsr_period got %h want 001", bus_b.cut_x); end
        checks++; if (bus_b.busy !== 1'b1 || bus_b.done !== 1'b0) begin errors++; $display("FAIL seed0_last_run busy=%b done=%b want 1 0", bus_b.busy, bus_b.done); end
        for (int k = 1025; k <= 1030; k++) begin
            cyc();
            if (bus_b.done === 1'b1 && done_at < 0) begin
                done_at = k;
                checks++; if (bus_b.pass !== 1'b1) begin errors++; $display("FAIL seed0_pass got %b want 1", bus_b.pass); end
                checks++; if (bus_b.pattern_cnt !== 11'd1024) begin errors++; $display("FAIL seed0_cnt got %0d want 1024", bus_b.pattern_cnt); end
            end
        end
        checks++; if (done_at !== 1025 + PIPE) begin errors++; $display("FAIL seed0_done_time got T+%0d want T+%0d", done_at, 1025 + PIPE); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.seed_in = 10'h000; bus_a.golden_sig = 15'h0000; bus_a.cut_f = 15'h0000;
        bus_b.start = 1'b0; bus_b.seed_in = 10'h000; bus_b.golden_sig = 15'h0000; bus_b.cut_f = 15'h0000;
        cyc();
        cyc();
        rst = 1'b0;
        test_reset();
        test_two_pattern();
        cyc();
        test_zero_response();
        test_back_to_back_start();
        cyc();
        test_reset_midrun();
        test_zero_seed_full_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
